// File: rtl/ransac_fixed.sv
// Fixed-point number format shared by the RANSAC plane-fit datapath.
package ransac_fixed;

  typedef logic signed [15:0] fixed_t;

  function automatic int unsigned value_bits();
    return $bits(fixed_t);
  endfunction

endpackage

// File: rtl/inlier_tally_if.sv
// Sample stream in, tally result out for inlier_tally.
interface inlier_tally_if #(
  parameter int unsigned count_bits = 16,
  parameter type         fixed_t    = ransac_fixed::fixed_t
);

  logic                  start;
  fixed_t                threshold;
  logic                  in_valid;
  logic                  in_last;
  fixed_t                distance;
  logic                  count_valid;
  logic                  count_ready;
  logic [count_bits-1:0] inlier_count;
  logic [count_bits-1:0] sample_count;
  logic                  busy;
  logic                  overrun;

  modport slave (
    input  start, threshold, in_valid, in_last, distance, count_ready,
    output count_valid, inlier_count, sample_count, busy, overrun
  );

  modport master (
    output start, threshold, in_valid, in_last, distance, count_ready,
    input  count_valid, inlier_count, sample_count, busy, overrun
  );

endinterface

// File: rtl/inlier_tally.sv
// Counts samples and inliers (|distance| <= threshold) over one plane's point set,
// then holds the result until the consumer takes it.
module inlier_tally #(
  parameter int unsigned count_bits = 16,
  parameter type         fixed_t    = ransac_fixed::fixed_t
) (
  input  logic           clock,
  input  logic           reset_n,
  inlier_tally_if.slave  bus
);

  localparam int unsigned W = $bits(fixed_t);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic [W-1:0]          thr_q;
  logic [W-1:0]          dist_mag;
  logic                  is_inlier;
  logic                  accept_start;
  logic                  take_sample;
  logic [count_bits-1:0] inl_q;
  logic [count_bits-1:0] smp_q;
  logic                  overrun_q;
  logic                  busy_q;
  logic                  cv_q;

  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    take_sample  = 1'b0;
    unique case (state)
      IDLE: begin
        accept_start = bus.start;
        if (bus.start) state_next = COLLECT;
      end
      COLLECT: begin
        take_sample = bus.in_valid;
        if (bus.in_valid && bus.in_last) state_next = DONE;
      end
      DONE: begin
        if (bus.count_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Most negative code has no positive twin; clamp its magnitude to the max positive code.
  always_comb begin
    dist_mag = bus.distance;
    if (bus.distance[W-1]) begin
      if (bus.distance[W-2:0] == '0) dist_mag = {1'b0, {(W-1){1'b1}}};
      else                           dist_mag = (~bus.distance) + 1'b1;
    end
    is_inlier = !thr_q[W-1] && (dist_mag <= thr_q);
  end

  // busy/count_valid are registered from the next state so outputs come straight from flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      cv_q   <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next == COLLECT);
      cv_q   <= (state_next == DONE);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      thr_q     <= '0;
      inl_q     <= '0;
      smp_q     <= '0;
      overrun_q <= 1'b0;
    end else if (accept_start) begin
      thr_q     <= bus.threshold;
      inl_q     <= '0;
      smp_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (take_sample) begin
        if (smp_q != '1)               smp_q <= smp_q + 1'b1;
        if (is_inlier && inl_q != '1)  inl_q <= inl_q + 1'b1;
      end
      if (bus.in_valid && state != COLLECT) overrun_q <= 1'b1;
    end
  end

  assign bus.count_valid  = cv_q;
  assign bus.busy         = busy_q;
  assign bus.inlier_count = inl_q;
  assign bus.sample_count = smp_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_inlier_tally.sv
// Bench for inlier_tally: table of tally cases plus hand sequences for handshake,
// overrun, saturation and reset abort; results checked through an expected-result queue.
module tb_inlier_tally;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  inlier_tally_if #(.count_bits(16)) b ();
  inlier_tally_if #(.count_bits(4))  b4 ();

  inlier_tally #(.count_bits(16)) dut (.clock(clock), .reset_n(reset_n), .bus(b));
  inlier_tally #(.count_bits(4))  dut4 (.clock(clock), .reset_n(reset_n), .bus(b4));

  typedef struct {
    logic signed [15:0]      thr;
    int                      n;
    logic [0:7][15:0]        d;
    int                      gap;
    bit                      poke;
    int                      exp_inl;
    int                      exp_smp;
  } vec_t;

  typedef struct {
    int inl;
    int smp;
  } exp_t;

  vec_t vecs[6];
  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic signed [15:0] thr, input string tag);
    b.start = 1'b1;
    b.threshold = thr;
    tick();
    b.start = 1'b0;
    check({tag, " busy after start"}, b.busy, 1);
    check({tag, " cv after start"}, b.count_valid, 0);
    check({tag, " smp cleared"}, b.sample_count, 0);
    check({tag, " overrun cleared"}, b.overrun, 0);
  endtask

  task automatic beat(input logic [15:0] d, input bit last);
    b.in_valid = 1'b1;
    b.distance = d;
    b.in_last = last;
    tick();
    b.in_valid = 1'b0;
    b.in_last = 1'b0;
  endtask

  task automatic await_result(input string tag);
    int   waited;
    exp_t e;
    waited = 0;
    while (!b.count_valid && waited < 8) begin
      tick();
      waited++;
    end
    check({tag, " latency"}, waited, 0);
    if (sbq.size() == 0) begin
      check({tag, " scoreboard empty"}, 1, 0);
      return;
    end
    e = sbq.pop_front();
    if (b.count_valid) begin
      check({tag, " inlier_count"}, b.inlier_count, e.inl);
      check({tag, " sample_count"}, b.sample_count, e.smp);
      check({tag, " busy in DONE"}, b.busy, 0);
    end else begin
      check({tag, " count_valid timeout"}, 0, 1);
    end
  endtask

  task automatic handshake(input string tag);
    b.count_ready = 1'b1;
    tick();
    b.count_ready = 1'b0;
    check({tag, " cv after handshake"}, b.count_valid, 0);
  endtask

  task automatic run_case(input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    do_start(vecs[idx].thr, tag);
    for (int i = 0; i < vecs[idx].n; i++) begin
      if (i == vecs[idx].gap) begin
        b.in_last = 1'b1;
        tick();
        b.in_last = 1'b0;
      end
      if (vecs[idx].poke && i == 1) begin
        b.start = 1'b1;
        b.threshold = 16'sd0;
      end
      if (i == vecs[idx].n - 1) sbq.push_back('{inl: vecs[idx].exp_inl, smp: vecs[idx].exp_smp});
      beat(vecs[idx].d[i], i == vecs[idx].n - 1);
      b.start = 1'b0;
    end
    await_result(tag);
    handshake(tag);
  endtask

  initial begin
    int waited;

    vecs[0] = '{thr: 16'sd8, n: 4, d: {16'd3, -16'sd8, 16'd9, -16'sd9, 64'd0},
                gap: -1, poke: 1'b1, exp_inl: 2, exp_smp: 4};
    vecs[1] = '{thr: 16'sd0, n: 3, d: {16'd0, 16'h8000, 16'd1, 80'd0},
                gap: -1, poke: 1'b0, exp_inl: 1, exp_smp: 3};
    vecs[2] = '{thr: -16'sd1, n: 3, d: {16'd0, 16'd1, 16'hFFFF, 80'd0},
                gap: 1, poke: 1'b0, exp_inl: 0, exp_smp: 3};
    vecs[3] = '{thr: 16'sh7FFF, n: 4, d: {16'h8000, 16'h7FFF, 16'h8001, 16'd5, 64'd0},
                gap: -1, poke: 1'b0, exp_inl: 4, exp_smp: 4};
    vecs[4] = '{thr: 16'sd100, n: 5, d: {16'd100, -16'sd100, 16'd101, -16'sd101, 16'd0, 48'd0},
                gap: 2, poke: 1'b0, exp_inl: 3, exp_smp: 5};
    vecs[5] = '{thr: 16'sd1, n: 1, d: {16'hFFFF, 112'd0},
                gap: -1, poke: 1'b0, exp_inl: 1, exp_smp: 1};

    b.start = 1'b0; b.threshold = '0; b.in_valid = 1'b0; b.in_last = 1'b0;
    b.distance = '0; b.count_ready = 1'b0;
    b4.start = 1'b0; b4.threshold = '0; b4.in_valid = 1'b0; b4.in_last = 1'b0;
    b4.distance = '0; b4.count_ready = 1'b0;

    #12;
    check("reset cv", b.count_valid, 0);
    check("reset busy", b.busy, 0);
    check("reset inl", b.inlier_count, 0);
    check("reset smp", b.sample_count, 0);
    check("reset overrun", b.overrun, 0);
    reset_n = 1'b1;

    for (int k = 0; k < 6; k++) run_case(k);

    // Overrun in IDLE, then stall in DONE with a stray sample and a start alongside ready.
    b.in_valid = 1'b1;
    tick();
    b.in_valid = 1'b0;
    check("idle overrun", b.overrun, 1);
    check("idle drop smp", b.sample_count, 1);
    do_start(16'sd5, "ovr");
    sbq.push_back('{inl: 2, smp: 3});
    beat(16'd5, 1'b0);
    beat(-16'sd6, 1'b0);
    beat(16'd0, 1'b1);
    await_result("ovr");
    for (int c = 0; c < 5; c++) begin
      b.in_valid = (c == 2);
      tick();
      b.in_valid = 1'b0;
      check("hold cv", b.count_valid, 1);
      check("hold inl", b.inlier_count, 2);
      check("hold smp", b.sample_count, 3);
    end
    check("done overrun", b.overrun, 1);
    b.count_ready = 1'b1;
    b.start = 1'b1;
    b.threshold = 16'sd7;
    tick();
    b.count_ready = 1'b0;
    b.start = 1'b0;
    check("ready+start cv", b.count_valid, 0);
    check("ready+start busy", b.busy, 0);
    tick();
    check("start ignored busy", b.busy, 0);
    check("start ignored overrun", b.overrun, 1);
    check("start ignored smp", b.sample_count, 3);

    // Saturation on the narrow instance.
    b4.start = 1'b1;
    b4.threshold = 16'sh7FFF;
    tick();
    b4.start = 1'b0;
    check("sat busy", b4.busy, 1);
    for (int i = 0; i < 20; i++) begin
      b4.in_valid = 1'b1;
      b4.distance = 16'(i * 1000 - 9000);
      b4.in_last = (i == 19);
      tick();
    end
    b4.in_valid = 1'b0;
    b4.in_last = 1'b0;
    waited = 0;
    while (!b4.count_valid && waited < 8) begin
      tick();
      waited++;
    end
    check("sat latency", waited, 0);
    check("sat inl", b4.inlier_count, 15);
    check("sat smp", b4.sample_count, 15);
    b4.count_ready = 1'b1;
    tick();
    b4.count_ready = 1'b0;
    check("sat handshake cv", b4.count_valid, 0);

    // Reset mid-collect aborts the tally; first start after release is honoured.
    do_start(16'sd8, "abort");
    beat(16'd1, 1'b0);
    beat(16'd2, 1'b0);
    beat(16'd3, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("abort cv", b.count_valid, 0);
    check("abort busy", b.busy, 0);
    check("abort inl", b.inlier_count, 0);
    check("abort smp", b.sample_count, 0);
    check("abort overrun", b.overrun, 0);
    tick();
    reset_n = 1'b1;
    do_start(16'sd0, "post");
    sbq.push_back('{inl: 1, smp: 1});
    beat(16'd0, 1'b1);
    await_result("post");
    handshake("post");
    check("scoreboard drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
